dcache_write_buffer: RTL and testbench

Posted-write buffer between the data cache and the main-memory bus. It accepts word-aligned byte-enabled stores from the data cache in one cycle, queues up to DEPTH of them, and drains them in order to memory over a req/ack handshake. It coalesces a store into the youngest queued entry when both target the same word. It also reports whether a pending store targets a given read address, so the cache can hold a miss refill until that store has drained.

---
 rtl/dcache_write_buffer_pkg.sv | 22 ++
 rtl/wb_addr_match.sv | 15 +
 rtl/dcache_write_buffer.sv | 165 ++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared types for the data-cache posted-write buffer.
//   DEPTH_DEFAULT : default number of queued stores
//   wb_entry_t    : one queued store (word address, data, lane enables)
//   mem_bus_req_t : memory-bus write request, also intended for the refill controller
package dcache_write_buffer_pkg;

  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] addr;    // word address, byte address bits [31:2]
    logic [31:0] data;
    logic [3:0]  byteen;  // byteen[3] covers data[31:24]
  } wb_entry_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } mem_bus_req_t;

endpackage

// File: rtl/wb_addr_match.sv
// Single-entry address comparator for the write buffer.
//   entry_valid : entry currently holds a queued store
//   entry_addr  : entry word address
//   rd_word     : word address being looked up
//   match       : entry is valid and its word address equals rd_word
module wb_addr_match (
  input  logic        entry_valid,
  input  logic [29:0] entry_addr,
  input  logic [29:0] rd_word,
  output logic        match
);

  assign match = entry_valid && (entry_addr == rd_word);

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the data cache and the memory bus.
// Stores are queued in a circular FIFO and drained in order over a req/ack
// handshake; a store to the same word as the youngest (not in-flight) entry
// is coalesced into it. rd_conflict flags any queued store to a read word.
//   clk, reset          : clock, asynchronous active-low reset
//   wr_valid/addr/data/byteen, wr_ready : store port from the cache
//   mem_req/addr/wdata/byteen, mem_ack  : write port to memory (head entry)
//   rd_addr, rd_conflict                : read-after-write hazard check
//   empty, count                        : occupancy
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_byteen,
  output logic                     wr_ready,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byteen,
  input  logic                     mem_ack,
  input  logic [31:0]              rd_addr,
  output logic                     rd_conflict,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entry_q [DEPTH];
  wb_entry_t        entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] young_ptr;
  wb_entry_t        young_entry;
  wb_entry_t        head_entry;
  logic             merge_hit;
  logic             pop;
  logic             wr_fire;
  logic             do_merge;
  logic             do_push;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] match_vec;

  // Address bits [1:0] never take part in word matching.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end
    return res;
  endfunction

  assign young_ptr   = tail_q - PTR_W'(1);
  assign young_entry = entry_q[young_ptr];
  assign head_entry  = entry_q[head_q];

  // With a single entry the youngest is the in-flight head, which must not
  // change, so coalescing needs at least two entries.
  assign merge_hit = (count_q >= CNT_W'(2)) && (young_entry.addr == wr_addr[31:2]);
  assign wr_ready  = (count_q < CNT_W'(DEPTH)) || merge_hit;

  assign mem_req    = (count_q != '0);
  assign pop        = mem_req && mem_ack;
  // Stores with no enabled lanes are accepted but leave no trace.
  assign wr_fire    = wr_valid && wr_ready && (wr_byteen != 4'b0000);
  // With two entries and a pop, the youngest becomes the new head on this
  // edge; push a fresh entry instead of merging into it.
  assign do_merge   = wr_fire && merge_hit && !(pop && (count_q == CNT_W'(2)));
  assign do_push    = wr_fire && !do_merge;

  // Payload is forced to zero while idle so the bus sees a clean value.
  assign mem_addr   = mem_req ? {head_entry.addr, 2'b00} : 32'h0;
  assign mem_wdata  = mem_req ? head_entry.data : 32'h0;
  assign mem_byteen = mem_req ? head_entry.byteen : 4'h0;

  assign empty = (count_q == '0);
  assign count = count_q;

  // Pointer and occupancy next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (do_push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage next state
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (do_push) begin
      entry_d[tail_q] = '{addr: wr_addr[31:2], data: wr_data, byteen: wr_byteen};
    end else if (do_merge) begin
      entry_d[young_ptr] = '{addr:   young_entry.addr,
                             data:   merge_lanes(young_entry.data, wr_data, wr_byteen),
                             byteen: young_entry.byteen | wr_byteen};
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data registers; validity comes from the control state
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  // An entry is valid when its distance from the head is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset       = PTR_W'(i) - head_q;
      valid_vec[i] = ({1'b0, offset} < count_q);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    wb_addr_match u_match (
      .entry_valid (valid_vec[g]),
      .entry_addr  (entry_q[g].addr),
      .rd_word     (rd_addr[31:2]),
      .match       (match_vec[g])
    );
  end

  assign rd_conflict = |match_vec;

endmodule

// File: tb/tb_dcache_write_buffer.sv
module tb_dcache_write_buffer;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byteen;
  logic        wr_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] rd_addr;
  logic        rd_conflict;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  dcache_write_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_byteen   (wr_byteen),
    .wr_ready    (wr_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_byteen  (mem_byteen),
    .mem_ack     (mem_ack),
    .rd_addr     (rd_addr),
    .rd_conflict (rd_conflict),
    .empty       (empty),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    wr_byteen = be;
  endtask

  initial begin
    reset   = 1'b0;
    mem_ack = 1'b0;
    rd_addr = 32'h0000_0304;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    // reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rd_conflict", 32'(rd_conflict), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    reset = 1'b1;
    tick();

    // single store, memory acks immediately
    mem_ack = 1'b1;
    set_wr(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    tick();
    wr_valid = 1'b0;
    check("t1_mem_req", 32'(mem_req), 32'd1);
    check("t1_mem_addr", mem_addr, 32'h0000_0100);
    check("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t1_mem_byteen", 32'(mem_byteen), 32'hF);
    tick();
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_mem_req_low", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // zero-byteen store is discarded
    set_wr(1'b1, 32'h0000_0500, 32'h1234_5678, 4'h0);
    #1;
    check("be0_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check("be0_count", 32'(count), 32'd0);

    // fill, stall, one pop, order preserved
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 32'h0000_1000 + 32'(i * 16), 32'hA0 + 32'(i), 4'hF);
      tick();
    end
    set_wr(1'b1, 32'h0000_1040, 32'hA4, 4'hF);
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_head", mem_addr, 32'h0000_1000);
    tick();
    check("stall_count", 32'(count), 32'd4);
    mem_ack = 1'b1;
    #1;
    check("no_passthru_ready", 32'(wr_ready), 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("pop_count", 32'(count), 32'd3);
    check("pop_wr_ready", 32'(wr_ready), 32'd1);
    check("pop_head", mem_addr, 32'h0000_1010);
    tick();
    wr_valid = 1'b0;
    check("refill_count", 32'(count), 32'd4);
    mem_ack = 1'b1;
    check("order_0", mem_addr, 32'h0000_1010);
    check("order_0_data", mem_wdata, 32'hA1);
    tick();
    check("order_1", mem_addr, 32'h0000_1020);
    check("order_1_req", 32'(mem_req), 32'd1);
    tick();
    check("order_2", mem_addr, 32'h0000_1030);
    tick();
    check("order_3", mem_addr, 32'h0000_1040);
    check("order_3_data", mem_wdata, 32'hA4);
    tick();
    check("drain_empty", 32'(empty), 32'd1);
    mem_ack = 1'b0;

    // coalescing into the youngest entry
    set_wr(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF);
    tick();
    set_wr(1'b1, 32'h0000_0204, 32'h1122_3344, 4'b1000);
    tick();
    check("merge_pre_count", 32'(count), 32'd2);
    set_wr(1'b1, 32'h0000_0206, 32'h0000_AA00, 4'b0010);
    tick();
    wr_valid = 1'b0;
    check("merge_count", 32'(count), 32'd2);
    mem_ack = 1'b1;
    check("merge_head", mem_addr, 32'h0000_0200);
    tick();
    check("merge_addr", mem_addr, 32'h0000_0204);
    check("merge_data", mem_wdata, 32'h1122_AA44);
    check("merge_byteen", 32'(mem_byteen), 32'hA);
    tick();
    check("merge_empty", 32'(empty), 32'd1);
    mem_ack = 1'b0;

    // push and pop on the same edge with one entry
    set_wr(1'b1, 32'h0000_0400, 32'h0000_0004, 4'hF);
    tick();
    set_wr(1'b1, 32'h0000_0404, 32'h0000_0005, 4'hF);
    mem_ack = 1'b1;
    check("pp_old_head", mem_addr, 32'h0000_0400);
    tick();
    wr_valid = 1'b0;
    check("pp_count", 32'(count), 32'd1);
    check("pp_new_head", mem_addr, 32'h0000_0404);
    check("pp_req", 32'(mem_req), 32'd1);
    tick();
    check("pp_empty", 32'(empty), 32'd1);
    mem_ack = 1'b0;

    // read conflict detection
    set_wr(1'b1, 32'h0000_0300, 32'h0000_0300, 4'hF);
    #1;
    check("rc_other_pre", 32'(rd_conflict), 32'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("rc_other_q", 32'(rd_conflict), 32'd0);
    rd_addr = 32'h0000_0302;
    #1;
    check("rc_hit", 32'(rd_conflict), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    check("rc_after_ack", 32'(rd_conflict), 32'd0);
    rd_addr = 32'h0000_0304;

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 32'h0000_0600 + 32'(i * 4), 32'h60 + 32'(i), 4'hF);
      tick();
    end
    wr_valid = 1'b0;
    rd_addr = 32'h0000_0604;
    #1;
    check("ar_pre_count", 32'(count), 32'd3);
    check("ar_pre_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("ar_req", 32'(mem_req), 32'd0);
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_rd_conflict", 32'(rd_conflict), 32'd0);
    check("ar_mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b1;
    set_wr(1'b1, 32'h0000_0700, 32'h0000_0077, 4'h3);
    tick();
    wr_valid = 1'b0;
    check("ar_new_count", 32'(count), 32'd1);
    check("ar_new_addr", mem_addr, 32'h0000_0700);
    check("ar_new_byteen", 32'(mem_byteen), 32'h3);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ar_final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
